// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu sequencer and the 16-bit ALU:
// opcodes, instruction field layout and sequencer states.
package cpu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_LOADI = 3'b100;
    localparam logic [2:0] OP_NOP5  = 3'b101;
    localparam logic [2:0] OP_NOP6  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 13;
    localparam int RD_HI  = 12;
    localparam int RD_LO  = 11;
    localparam int RS1_HI = 10;
    localparam int RS1_LO = 9;
    localparam int RS2_HI = 8;
    localparam int RS2_LO = 7;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WAIT,
        S_HALTED
    } cpu_seq_state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [7:0] imm;
    } instr_t;

    function automatic instr_t decode(input logic [15:0] w);
        instr_t d;
        d.op  = w[OP_HI:OP_LO];
        d.rd  = w[RD_HI:RD_LO];
        d.rs1 = w[RS1_HI:RS1_LO];
        d.rs2 = w[RS2_HI:RS2_LO];
        d.imm = w[IMM_HI:IMM_LO];
        return d;
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/regfile_4x16.sv
// Four 16-bit registers: two operand read ports, one debug read
// port, one synchronous write port, asynchronous clear.
module regfile_4x16 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [1:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  raddr_a_i,
    input  logic [1:0]  raddr_b_i,
    input  logic [1:0]  dbg_sel_i,
    output logic [15:0] rdata_a_o,
    output logic [15:0] rdata_b_o,
    output logic [15:0] dbg_data_o
);

    logic [15:0] regs_q [4];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '{default: '0};
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = regs_q[raddr_a_i];
    assign rdata_b_o  = regs_q[raddr_b_i];
    assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer feeding the 16-bit ALU; LOADI and
// HALT are executed locally, ALU ops wait for the done pulse.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic            alu_start,
    output logic [2:0]      alu_opcode,
    output logic [15:0]     alu_a,
    output logic [15:0]     alu_b,
    input  logic [15:0]     alu_result,
    input  logic            alu_done,
    output logic            busy,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    input  logic [1:0]      dbg_sel,
    output logic [15:0]     dbg_data
);

    cpu_seq_state_t state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            start_q, start_d;
    logic [2:0]      opcode_q, opcode_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;

    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;

    instr_t dec;
    instr_t ir_dec;
    logic   is_alu;
    logic   is_loadi;
    logic   is_halt;
    logic   is_nop;

    // Decode straight off the memory port; IR only keeps rd for WAIT.
    assign dec      = decode(imem_rdata);
    assign ir_dec   = decode(ir_q);
    assign is_alu   = (dec.op[2] == 1'b0);
    assign is_loadi = (dec.op == OP_LOADI);
    assign is_halt  = (dec.op == OP_HALT);
    assign is_nop   = (dec.op == OP_NOP5) || (dec.op == OP_NOP6);

    logic unused_ir;
    assign unused_ir = ^{ir_dec.op, ir_dec.rs1, ir_dec.rs2, ir_dec.imm};

    regfile_4x16 u_regfile (
        .clk_i      (clk),
        .rst_ni     (reset),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (rf_wdata),
        .raddr_a_i  (dec.rs1),
        .raddr_b_i  (dec.rs2),
        .dbg_sel_i  (dbg_sel),
        .rdata_a_o  (rs1_data),
        .rdata_b_o  (rs2_data),
        .dbg_data_o (dbg_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            start_q  <= 1'b0;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            start_q  <= start_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        start_d  = 1'b0;
        opcode_d = opcode_q;
        a_d      = a_q;
        b_d      = b_q;
        rf_we    = 1'b0;
        rf_waddr = ir_dec.rd;
        rf_wdata = alu_result;

        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (run) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d = imem_rdata;
                unique case (1'b1)
                    is_alu: begin
                        a_d      = rs1_data;
                        b_d      = rs2_data;
                        opcode_d = dec.op;
                        start_d  = 1'b1;
                        state_d  = S_WAIT;
                    end
                    is_loadi: begin
                        rf_we    = 1'b1;
                        rf_waddr = dec.rd;
                        rf_wdata = sext8(dec.imm);
                        pc_d     = pc_q + PC_W'(1);
                        state_d  = S_FETCH;
                    end
                    is_halt: begin
                        state_d = S_HALTED;
                    end
                    is_nop: begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_WAIT: begin
                if (alu_done) begin
                    rf_we   = 1'b1;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign alu_start  = start_q;
    assign alu_opcode = opcode_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted     = (state_q == S_HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: program memories, an ALU model with
// per-opcode latency, and a register scoreboard drained after HALT.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0;
    logic        alu_start;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_result;
    logic        alu_done;
    logic        busy, halted;
    logic [7:0]  pc;
    logic [1:0]  dbg_sel = 2'd0;
    logic [15:0] dbg_data;

    logic        run2 = 1'b0;
    logic [1:0]  imem_addr2;
    logic [15:0] imem_rdata2 = 16'h0;
    logic        alu_start2;
    logic [2:0]  alu_opcode2;
    logic [15:0] alu_a2, alu_b2;
    logic        busy2, halted2;
    logic [1:0]  pc2;
    logic [15:0] dbg_data2;

    cpu_sequencer #(.PC_W(8)) u_dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .alu_start(alu_start), .alu_opcode(alu_opcode),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_done(alu_done),
        .busy(busy), .halted(halted), .pc(pc),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    cpu_sequencer #(.PC_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .run(run2),
        .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .alu_start(alu_start2), .alu_opcode(alu_opcode2),
        .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_result(16'h0), .alu_done(1'b0),
        .busy(busy2), .halted(halted2), .pc(pc2),
        .dbg_sel(2'd0), .dbg_data(dbg_data2)
    );

    logic [15:0] mem [256];
    logic [15:0] mem2 [4];
    always @(posedge clk) imem_rdata <= mem[imem_addr];
    always @(posedge clk) imem_rdata2 <= mem2[imem_addr2];

    // ALU model: add/sub answer 1 cycle after start, div 4, mul 6.
    logic [15:0] res = 16'h0;
    logic        mdone = 1'b0;
    logic        inj = 1'b0;
    int          lat_cnt = 0;
    assign alu_result = res;
    assign alu_done   = mdone | inj;

    function automatic int lat_of(input logic [2:0] op);
        case (op)
            3'b010:  return 6;
            3'b011:  return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] alu_fn(input logic [2:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic signed [15:0] sa, sb;
        logic signed [31:0] p;
        sa = a;
        sb = b;
        p  = sa * sb;
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return p[15:0];
            default: return (sb == 0) ? 16'hFFFF : 16'(sa / sb);
        endcase
    endfunction

    always @(posedge clk) begin
        mdone <= 1'b0;
        if (alu_start) begin
            res <= alu_fn(alu_opcode, alu_a, alu_b);
            if (lat_of(alu_opcode) == 1) mdone <= 1'b1;
            else lat_cnt <= lat_of(alu_opcode) - 1;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) mdone <= 1'b1;
        end
    end

    int starts = 0;
    int dones = 0;
    always @(negedge clk) begin
        if (alu_start) starts = starts + 1;
        if (mdone) dones = dones + 1;
    end

    typedef struct {
        logic [1:0]  r;
        logic [15:0] v;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;

    function automatic logic [15:0] enc(input logic [2:0] op,
                                        input logic [1:0] rd,
                                        input logic [1:0] rs1,
                                        input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 7'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd,
                                        input logic [7:0] imm);
        return {3'b100, rd, 3'b000, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    endtask

    task automatic push(input logic [1:0] r, input logic [15:0] v);
        exp_t e;
        e.r = r;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic run_pulse();
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
    endtask

    task automatic wait_halt(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        total++;
        if ({busy, halted, alu_start} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000", {busy, halted, alu_start});
        end
        total++;
        if ({alu_opcode, alu_a, alu_b} !== 35'h0) begin
            bad++;
            $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_opcode, alu_a, alu_b);
        end
        total++;
        if (pc !== 8'h0 || imem_addr !== 8'h0) begin
            bad++;
            $display("FAIL reset_pc got=%h/%h exp=0", pc, imem_addr);
        end
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            total++;
            if (dbg_data !== 16'h0) begin
                bad++;
                $display("FAIL reset_reg r%0d got=%h exp=0000", r, dbg_data);
            end
        end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_add();
        bit ok;
        exp_t e;
        clear_mem();
        mem[0] = ldi(2'd1, 8'd5);
        mem[1] = ldi(2'd2, 8'hFD);
        mem[2] = enc(3'b000, 2'd3, 2'd1, 2'd2);
        push(2'd1, 16'd5);
        push(2'd2, 16'hFFFD);
        push(2'd3, 16'd2);
        starts = 0;
        run_pulse();
        wait_halt(100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL add_timeout halted=%b exp=1", halted);
        end
        total++;
        if (pc !== 8'd3) begin
            bad++;
            $display("FAIL add_pc got=%0d exp=3", pc);
        end
        total++;
        if (starts != 1) begin
            bad++;
            $display("FAIL add_starts got=%0d exp=1", starts);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dbg_sel = e.r;
            #1;
            total++;
            if (dbg_data !== e.v) begin
                bad++;
                $display("FAIL add_reg r%0d got=%h exp=%h", e.r, dbg_data, e.v);
            end
        end
    endtask

    task automatic test_sub_mul();
        exp_t e;
        int c2, c3, stab_bad;
        bit in_op;
        logic [15:0] ca, cb;
        c2 = 0;
        c3 = 0;
        stab_bad = 0;
        in_op = 1'b0;
        ca = '0;
        cb = '0;
        clear_mem();
        mem[0] = ldi(2'd1, 8'd7);
        mem[1] = ldi(2'd2, 8'hFC);
        mem[2] = enc(3'b001, 2'd0, 2'd1, 2'd2);
        mem[3] = enc(3'b010, 2'd3, 2'd1, 2'd2);
        push(2'd0, 16'd11);
        push(2'd3, 16'hFFE4);
        run_pulse();
        for (int i = 0; i < 200 && !halted; i++) begin
            @(negedge clk);
            if (pc == 8'd2) c2++;
            if (pc == 8'd3) c3++;
            if (alu_start) begin
                in_op = 1'b1;
                ca = alu_a;
                cb = alu_b;
            end else if (in_op) begin
                if (alu_a !== ca || alu_b !== cb) stab_bad++;
            end
            if (alu_done) in_op = 1'b0;
        end
        total++;
        if (!halted) begin
            bad++;
            $display("FAIL submul_timeout halted=%b exp=1", halted);
        end
        total++;
        if (c2 != 4) begin
            bad++;
            $display("FAIL sub_cycles got=%0d exp=4", c2);
        end
        total++;
        if (c3 != 9) begin
            bad++;
            $display("FAIL mul_cycles got=%0d exp=9", c3);
        end
        total++;
        if (stab_bad != 0) begin
            bad++;
            $display("FAIL operand_stable got=%0d exp=0", stab_bad);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dbg_sel = e.r;
            #1;
            total++;
            if (dbg_data !== e.v) begin
                bad++;
                $display("FAIL submul_reg r%0d got=%h exp=%h", e.r, dbg_data, e.v);
            end
        end
    endtask

    task automatic test_div_spurious();
        bit ok;
        exp_t e;
        clear_mem();
        mem[0] = ldi(2'd1, 8'd100);
        mem[1] = ldi(2'd2, 8'd7);
        mem[2] = enc(3'b011, 2'd3, 2'd1, 2'd2);
        push(2'd0, 16'd11);
        push(2'd1, 16'd100);
        push(2'd2, 16'd7);
        push(2'd3, 16'd14);
        run_pulse();
        inj = 1'b1;
        @(negedge clk) inj = 1'b0;
        wait_halt(100, ok);
        total++;
        if (!ok || pc !== 8'd3) begin
            bad++;
            $display("FAIL div_halt got=%b/%0d exp=1/3", halted, pc);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dbg_sel = e.r;
            #1;
            total++;
            if (dbg_data !== e.v) begin
                bad++;
                $display("FAIL div_reg r%0d got=%h exp=%h", e.r, dbg_data, e.v);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok, seen;
        int d0;
        exp_t e;
        do_reset();
        clear_mem();
        mem[0] = ldi(2'd1, 8'd7);
        mem[1] = ldi(2'd2, 8'hFC);
        mem[2] = enc(3'b010, 2'd3, 2'd1, 2'd2);
        run_pulse();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (alu_start) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL midwait_start got=0 exp=1");
        end
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        total++;
        if ({busy, halted, alu_start, alu_opcode} !== 6'b0) begin
            bad++;
            $display("FAIL midwait_flags got=%b exp=0", {busy, halted, alu_start, alu_opcode});
        end
        total++;
        if (alu_a !== 16'h0 || alu_b !== 16'h0 || pc !== 8'h0) begin
            bad++;
            $display("FAIL midwait_out got=%h/%h/%h exp=0", alu_a, alu_b, pc);
        end
        dbg_sel = 2'd1;
        #1;
        total++;
        if (dbg_data !== 16'h0) begin
            bad++;
            $display("FAIL midwait_clear got=%h exp=0000", dbg_data);
        end
        d0 = dones;
        @(negedge clk) reset = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (dones == d0) begin
            bad++;
            $display("FAIL late_done_seen got=0 exp=1");
        end
        dbg_sel = 2'd3;
        #1;
        total++;
        if (dbg_data !== 16'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL late_done_ignored got=%h/%b exp=0000/0", dbg_data, busy);
        end
        run_pulse();
        total++;
        if (pc !== 8'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL restart got=%0d/%b exp=0/1", pc, busy);
        end
        push(2'd3, 16'hFFE4);
        wait_halt(100, ok);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dbg_sel = e.r;
            #1;
            total++;
            if (dbg_data !== e.v || !ok) begin
                bad++;
                $display("FAIL restart_reg r%0d got=%h exp=%h", e.r, dbg_data, e.v);
            end
        end
    endtask

    task automatic test_nop_loadi();
        bit ok;
        int c0;
        exp_t e;
        do_reset();
        clear_mem();
        mem[0] = 16'hA000;
        mem[1] = 16'hC000;
        mem[2] = ldi(2'd2, 8'h80);
        push(2'd0, 16'h0);
        push(2'd1, 16'h0);
        push(2'd2, 16'hFF80);
        push(2'd3, 16'h0);
        starts = 0;
        c0 = 1;
        run_pulse();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pc == 8'd0) c0++;
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok || pc !== 8'd3) begin
            bad++;
            $display("FAIL nop_pc got=%b/%0d exp=1/3", halted, pc);
        end
        total++;
        if (c0 != 2) begin
            bad++;
            $display("FAIL nop_cycles got=%0d exp=2", c0);
        end
        total++;
        if (starts != 0) begin
            bad++;
            $display("FAIL nop_alu got=%0d exp=0", starts);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dbg_sel = e.r;
            #1;
            total++;
            if (dbg_data !== e.v) begin
                bad++;
                $display("FAIL nop_reg r%0d got=%h exp=%h", e.r, dbg_data, e.v);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_pc[$];
        logic [1:0] got, prev;
        int nb;
        for (int i = 0; i < 4; i++) mem2[i] = 16'hA000;
        for (int k = 0; k < 2; k++) begin
            exp_pc.push_back(2'd1);
            exp_pc.push_back(2'd2);
            exp_pc.push_back(2'd3);
            exp_pc.push_back(2'd0);
        end
        @(negedge clk) run2 = 1'b1;
        @(negedge clk) run2 = 1'b0;
        prev = pc2;
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            run2 = (i == 5);
            if (!busy2) nb++;
            if (pc2 != prev) begin
                got = pc2;
                prev = pc2;
                total++;
                if (exp_pc.size() == 0) begin
                    bad++;
                    $display("FAIL wrap_extra got=%0d", got);
                end else if (got !== exp_pc[0]) begin
                    bad++;
                    $display("FAIL wrap_pc got=%0d exp=%0d", got, exp_pc[0]);
                    void'(exp_pc.pop_front());
                end else begin
                    void'(exp_pc.pop_front());
                end
            end
        end
        run2 = 1'b0;
        total++;
        if (exp_pc.size() > 1 || nb != 0) begin
            bad++;
            $display("FAIL wrap_progress got=%0d/%0d exp<=1/0", exp_pc.size(), nb);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
        for (int i = 0; i < 4; i++) mem2[i] = 16'hA000;
        #2;
        test_reset();
        test_add();
        test_sub_mul();
        test_div_spurious();
        test_reset_mid_wait();
        test_nop_loadi();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
